// File: rtl/ddr1_req_queue_if.sv
// Host request bus and DDR1 controller request/response bus
// seen by the request queue front end.
interface ddr1_req_queue_if #(
  parameter int AW = 25,
  parameter int DW = 16
);
  logic          host_valid;
  logic          host_ready;
  logic          host_rw;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          req_valid;
  logic          req_rw;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ack;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;

  modport slave (
    input  host_valid, host_rw, host_addr, host_wdata,
    input  req_ack, resp_valid, resp_rdata,
    output host_ready, host_rvalid, host_rdata,
    output req_valid, req_rw, req_addr, req_wdata
  );

  modport master (
    output host_valid, host_rw, host_addr, host_wdata,
    output req_ack, resp_valid, resp_rdata,
    input  host_ready, host_rvalid, host_rdata,
    input  req_valid, req_rw, req_addr, req_wdata
  );
endinterface

// File: rtl/ddr1_req_queue.sv
// DDR1 host request queue: FIFO-buffered requests issued one at a
// time to the command controller, with in-order read return.
module ddr1_req_queue #(
  parameter int DEPTH      = 8,
  parameter int AW         = 25,
  parameter int DW         = 16,
  parameter int WR_HOLD    = 6,
  parameter int RD_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ddr1_req_queue_if.slave        bus,
  output logic [$clog2(DEPTH):0] q_level,
  output logic                   busy,
  output logic                   rd_timeout_err,
  input  logic                   err_clr
);
  localparam int PW   = $clog2(DEPTH);
  localparam int LW   = PW + 1;
  localparam int CMAX = (RD_TIMEOUT > WR_HOLD) ? RD_TIMEOUT : WR_HOLD;
  localparam int CW   = $clog2(CMAX) + 1;

  localparam logic [CW-1:0] RD_LAST = CW'(RD_TIMEOUT - 1);
  localparam logic [CW-1:0] WR_LAST = CW'(WR_HOLD - 1);
  localparam logic [LW-1:0] FULL    = LW'(DEPTH);

  localparam int S_IDLE  = 0;
  localparam int S_ISSUE = 1;
  localparam int S_RD    = 2;
  localparam int S_WR    = 3;

  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_ISSUE = 4'b0010;
  localparam logic [3:0] ST_RD    = 4'b0100;
  localparam logic [3:0] ST_WR    = 4'b1000;

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } ent_t;

  ent_t          mem [DEPTH];
  ent_t          head;
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [3:0]    st;
  logic [3:0]    nxt;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;
  logic          empty;
  logic          rd_hit;
  logic          rd_tmo;
  logic          cnt_run;

  assign empty          = (q_level == '0);
  assign bus.host_ready = (q_level != FULL);
  assign push           = bus.host_valid && bus.host_ready;
  assign head           = mem[rp];
  assign bus.req_valid  = st[S_ISSUE];
  assign busy           = !st[S_IDLE] || !empty;

  // storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push)
      mem[wp] <= {bus.host_rw, bus.host_addr, bus.host_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp      <= '0;
      rp      <= '0;
      q_level <= '0;
    end else begin
      if (push)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      q_level <= q_level + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      st <= ST_IDLE;
    else
      st <= nxt;
  end

  always_comb begin
    nxt = st;
    unique case (1'b1)
      st[S_IDLE]:  if (!empty) nxt = ST_ISSUE;
      st[S_ISSUE]: if (bus.req_ack)
                     nxt = bus.req_rw ? ST_RD : ST_WR;
      st[S_RD]:    if (bus.resp_valid || cnt == RD_LAST)
                     nxt = ST_IDLE;
      st[S_WR]:    if (cnt == WR_LAST) nxt = ST_IDLE;
      default:     nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pop     = 1'b0;
    rd_hit  = 1'b0;
    rd_tmo  = 1'b0;
    cnt_run = 1'b0;
    unique case (1'b1)
      st[S_IDLE]:  pop = !empty;
      st[S_ISSUE]: ;
      st[S_RD]: begin
        rd_hit  = bus.resp_valid;
        rd_tmo  = !bus.resp_valid && (cnt == RD_LAST);
        cnt_run = !bus.resp_valid;
      end
      st[S_WR]:    cnt_run = 1'b1;
      default:     ;
    endcase
  end

  // a lost read still returns a zero beat so host ordering holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.req_rw      <= 1'b0;
      bus.req_addr    <= '0;
      bus.req_wdata   <= '0;
      bus.host_rvalid <= 1'b0;
      bus.host_rdata  <= '0;
      cnt             <= '0;
      rd_timeout_err  <= 1'b0;
    end else begin
      if (pop)
        {bus.req_rw, bus.req_addr, bus.req_wdata} <= head;
      if (st[S_ISSUE])
        cnt <= '0;
      else if (cnt_run)
        cnt <= cnt + 1'b1;
      bus.host_rvalid <= rd_hit || rd_tmo;
      if (rd_hit)
        bus.host_rdata <= bus.resp_rdata;
      else if (rd_tmo)
        bus.host_rdata <= '0;
      if (rd_tmo)
        rd_timeout_err <= 1'b1;
      else if (err_clr)
        rd_timeout_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ddr1_req_queue.sv
// Bench for ddr1_req_queue: directed scenarios plus random traffic
// checked against a timeline model of queue and controller.
module tb_ddr1_req_queue;
  localparam int DEPTH      = 8;
  localparam int AW         = 25;
  localparam int DW         = 16;
  localparam int WR_HOLD    = 6;
  localparam int RD_TIMEOUT = 64;
  localparam int LW         = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          err_clr = 1'b0;
  logic [LW-1:0] q_level;
  logic          busy;
  logic          rd_timeout_err;

  ddr1_req_queue_if #(.AW(AW), .DW(DW)) bus ();

  ddr1_req_queue #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW),
    .WR_HOLD(WR_HOLD), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .q_level(q_level),
    .busy(busy),
    .rd_timeout_err(rd_timeout_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: pending requests, the one at the controller, and timestamps
  req_t          mq[$];
  req_t          cur;
  bit            have_cur, acked, m_err;
  int            ack_cyc, wait_cnt, cyc;
  bit            stall, spur_ack, spur_rsp, rsp_en, rsp_fix, rnd_mode;
  int            ack_dly, rsp_dly;
  logic [DW-1:0] rsp_val;
  logic [DW-1:0] last_rd;
  int            rv_cnt;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(output bit acc);
    bit            rise, done, exp_rv, tmo;
    logic [DW-1:0] exp_rd;
    int            e;
    e = cyc + 1;
    bus.req_ack    = spur_ack;
    bus.resp_valid = spur_rsp;
    bus.resp_rdata = rsp_fix ? rsp_val : DW'($urandom);
    if (have_cur && !acked && !stall && wait_cnt >= ack_dly)
      bus.req_ack = 1'b1;
    if (have_cur && acked && cur.rw && rsp_en && e - ack_cyc == rsp_dly)
      bus.resp_valid = 1'b1;
    acc    = bus.host_valid && (mq.size() != DEPTH);
    rise   = !have_cur && (mq.size() != 0);
    done   = 1'b0;
    exp_rv = 1'b0;
    exp_rd = '0;
    tmo    = 1'b0;
    if (have_cur && !acked) begin
      if (bus.req_ack) begin
        acked   = 1'b1;
        ack_cyc = e;
      end else begin
        wait_cnt++;
      end
    end else if (have_cur && cur.rw) begin
      if (bus.resp_valid) begin
        exp_rv = 1'b1;
        exp_rd = bus.resp_rdata;
        done   = 1'b1;
      end else if (e - ack_cyc == RD_TIMEOUT) begin
        exp_rv = 1'b1;
        tmo    = 1'b1;
        done   = 1'b1;
      end
    end else if (have_cur) begin
      if (e - ack_cyc == WR_HOLD)
        done = 1'b1;
    end
    if (tmo)
      m_err = 1'b1;
    else if (err_clr)
      m_err = 1'b0;
    if (done)
      have_cur = 1'b0;
    if (rise) begin
      cur      = mq.pop_front();
      have_cur = 1'b1;
      acked    = 1'b0;
      wait_cnt = 0;
      if (rnd_mode) begin
        ack_dly = $urandom_range(0, 3);
        rsp_dly = $urandom_range(1, 8);
        rsp_en  = ($urandom_range(0, 9) != 0);
      end
    end
    if (acc)
      mq.push_back({bus.host_rw, bus.host_addr, bus.host_wdata});
    @(posedge clk);
    #1;
    cyc = e;
    if (bus.host_rvalid === 1'b1) begin
      rv_cnt++;
      last_rd = bus.host_rdata;
    end
    chk("req_valid", 64'(bus.req_valid), 64'(have_cur && !acked));
    if (have_cur)
      chk("req_fields", 64'({bus.req_rw, bus.req_addr, bus.req_wdata}),
          64'(cur));
    chk("host_rvalid", 64'(bus.host_rvalid), 64'(exp_rv));
    if (exp_rv)
      chk("host_rdata", 64'(bus.host_rdata), 64'(exp_rd));
    chk("rd_timeout_err", 64'(rd_timeout_err), 64'(m_err));
    chk("q_level", 64'(q_level), 64'(mq.size()));
    chk("host_ready", 64'(bus.host_ready), 64'(mq.size() != DEPTH));
    chk("busy", 64'(busy), 64'(have_cur || mq.size() != 0));
  endtask

  task automatic tick();
    bit a;
    step(a);
  endtask

  task automatic push_req(input bit rw, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    bus.host_valid = 1'b1;
    bus.host_rw    = rw;
    bus.host_addr  = a;
    bus.host_wdata = d;
    while (!acc && n < 400) begin
      step(acc);
      n++;
    end
    bus.host_valid = 1'b0;
    chk("push_accept", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((have_cur || mq.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    tick();
    chk("drain_busy", 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    bus.host_valid = 1'b0;
    bus.req_ack    = 1'b0;
    bus.resp_valid = 1'b0;
    err_clr        = 1'b0;
    rst_n          = 1'b0;
    #1;
    chk("rst_req_valid", 64'(bus.req_valid), 64'd0);
    chk("rst_q_level", 64'(q_level), 64'd0);
    chk("rst_host_ready", 64'(bus.host_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rvalid", 64'(bus.host_rvalid), 64'd0);
    mq.delete();
    have_cur = 1'b0;
    acked    = 1'b0;
    m_err    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int rv0;
    int n;
    bus.host_valid = 1'b0;
    bus.host_rw    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.req_ack    = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    have_cur = 1'b0; acked = 1'b0; m_err = 1'b0;
    ack_cyc = 0; wait_cnt = 0; cyc = 0; rv_cnt = 0;
    stall = 1'b0; spur_ack = 1'b0; spur_rsp = 1'b0;
    rsp_en = 1'b1; rsp_fix = 1'b1; rnd_mode = 1'b0;
    ack_dly = 0; rsp_dly = 4; rsp_val = 16'hA5A5; last_rd = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_valid", 64'(bus.req_valid), 64'd0);
    chk("reset_host_ready", 64'(bus.host_ready), 64'd1);
    chk("reset_q_level", 64'(q_level), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rvalid", 64'(bus.host_rvalid), 64'd0);
    chk("reset_rdata", 64'(bus.host_rdata), 64'd0);
    chk("reset_err", 64'(rd_timeout_err), 64'd0);
    chk("reset_req_fields", 64'({bus.req_rw, bus.req_addr, bus.req_wdata}),
        64'd0);
    rst_n = 1'b1;
    tick();

    // single write
    rv0 = rv_cnt;
    push_req(1'b0, 25'h0123456, 16'hBEEF);
    drain();
    chk("wr_no_rvalid", 64'(rv_cnt - rv0), 64'd0);

    // single read, data four cycles after ack
    rv0 = rv_cnt;
    rsp_dly = 4;
    push_req(1'b1, 25'h1000040, 16'h0000);
    drain();
    chk("rd_rvalid_count", 64'(rv_cnt - rv0), 64'd1);
    chk("rd_data", 64'(last_rd), 64'hA5A5);
    chk("rd_no_err", 64'(rd_timeout_err), 64'd0);

    // fill with controller stalled, then release
    rv0 = rv_cnt;
    stall = 1'b1;
    rsp_fix = 1'b0;
    rsp_dly = 3;
    for (int i = 0; i < 9; i++)
      push_req(i % 3 == 1, AW'(32'h100 + i * 64), DW'(16'h1000 + i));
    chk("full_level", 64'(q_level), 64'(DEPTH));
    chk("full_ready", 64'(bus.host_ready), 64'd0);
    bus.host_valid = 1'b1;
    bus.host_rw    = 1'b0;
    bus.host_addr  = 25'h1FFFFFF;
    bus.host_wdata = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      step(acc);
      chk("full_held", 64'(acc), 64'd0);
    end
    stall = 1'b0;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      step(acc);
      n++;
    end
    bus.host_valid = 1'b0;
    chk("held_accepted", 64'(acc), 64'd1);
    drain();
    chk("fill_rd_count", 64'(rv_cnt - rv0), 64'd3);

    // lost read, then set-vs-clear collision, then clear alone
    rsp_en = 1'b0;
    rv0 = rv_cnt;
    push_req(1'b1, 25'h0000ABC, 16'h0);
    drain();
    chk("tmo_err", 64'(rd_timeout_err), 64'd1);
    chk("tmo_rvalid", 64'(rv_cnt - rv0), 64'd1);
    chk("tmo_rdata", 64'(last_rd), 64'd0);
    push_req(1'b1, 25'h0000ABD, 16'h0);
    n = 0;
    while (!(have_cur && acked && cyc + 1 - ack_cyc == RD_TIMEOUT) && n < 200) begin
      tick();
      n++;
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("set_wins", 64'(rd_timeout_err), 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared", 64'(rd_timeout_err), 64'd0);
    drain();

    // spurious ack in idle, spurious resp during write hold
    rv0 = rv_cnt;
    spur_ack = 1'b1;
    repeat (4) tick();
    spur_ack = 1'b0;
    chk("spur_ack_busy", 64'(busy), 64'd0);
    push_req(1'b0, 25'h0055AA0, 16'h1234);
    n = 0;
    while (!(have_cur && acked) && n < 50) begin
      tick();
      n++;
    end
    spur_rsp = 1'b1;
    repeat (3) tick();
    spur_rsp = 1'b0;
    drain();
    spur_rsp = 1'b1;
    repeat (2) tick();
    spur_rsp = 1'b0;
    chk("spur_no_rvalid", 64'(rv_cnt - rv0), 64'd0);

    // reset in WAIT_RD with three entries queued
    push_req(1'b1, 25'h0000100, 16'h0);
    for (int i = 0; i < 3; i++)
      push_req(1'b0, AW'(32'h200 + i), DW'(i));
    n = 0;
    while (!(have_cur && acked) && n < 50) begin
      tick();
      n++;
    end
    chk("pre_rst_level", 64'(q_level), 64'd3);
    do_reset();
    rv0 = rv_cnt;
    repeat (10) tick();
    chk("post_rst_rvalid", 64'(rv_cnt - rv0), 64'd0);

    // reset while a request is being offered
    stall = 1'b1;
    push_req(1'b0, 25'h0000300, 16'h0);
    tick();
    chk("issue_req_valid", 64'(bus.req_valid), 64'd1);
    do_reset();
    stall = 1'b0;
    rsp_en = 1'b1;
    repeat (3) tick();

    // random traffic
    rnd_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      push_req(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
    end
    drain();
    rnd_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
